// File: rtl/mips_cpu_muldiv_ctrl.sv
// HI/LO owner for the MIPS CPU: iterative shift-add multiply and restoring divide.
// Define MIPS_CPU_MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module mips_cpu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           opl;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [2*WIDTH-1:0]   acc;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    logic               is_div, sgn, neg_q, neg_r, in_sgn;
    logic [WIDTH-1:0]   ma, mb, in_ma, in_mb;
    logic [WIDTH:0]     add_sum, rsh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod, prod_s;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        is_div = opl[1];
        sgn    = ~opl[0];
        ma     = mag(a_r, sgn);
        mb     = mag(b_r, sgn);
        neg_q  = sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        neg_r  = sgn & a_r[WIDTH-1];
        in_sgn = ~op[0];
        in_ma  = mag(A, in_sgn);
        in_mb  = mag(B, in_sgn);

        // Multiply: acc = {partial sum, remaining multiplier bits}
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma : {WIDTH{1'b0}})};
        mul_next = {add_sum, acc[WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits shifting into quotient}
        rsh      = acc[2*WIDTH-1:WIDTH-1];
        diff     = rsh - {1'b0, mb};
        div_next = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
        prod = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
`else
        prod = acc;
`endif
        prod_s = neg_q ? -prod : prod;

        if (!is_div) begin
            fix_hi = prod_s[2*WIDTH-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end else if (b_r == '0) begin
            fix_hi = a_r;
            fix_lo = '1;
        end else begin
            fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            opl   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opl  <= op;
                            a_r  <= A;
                            b_r  <= B;
                            acc  <= {{WIDTH{1'b0}}, in_mb};
                            cnt  <= '0;
                            busy <= 1'b1;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
                            state <= FIX;
`else
                            state <= RUN;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            opl   <= op;
                            a_r   <= A;
                            b_r   <= B;
                            acc   <= {{WIDTH{1'b0}}, in_ma};
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= (B == '0) ? FIX : RUN;
                        end
                        OP_MTHI: hi <= A;
                        OP_MTLO: lo <= A;
                        default: ;
                    endcase
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed bench for mips_cpu_muldiv_ctrl with a result scoreboard and latency/busy/hold checks.
module tb_mips_cpu_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset, op_valid, busy, done;
    logic [2:0]  op;
    logic [31:0] A, B, hi, lo;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] sb_q[$];

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    mips_cpu_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results {hi, lo}, computed with native 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'b0;
        endcase
    endfunction

    // Called just after a negedge; returns at the negedge where done is observed.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit inj);
        logic [63:0] e;
        logic [31:0] h0, l0;
        int n;
        bit hold_ok, busy_ok;
        h0 = hi; l0 = lo; hold_ok = 1; busy_ok = 1; n = 0;
        sb_q.push_back(model(o, a, b));
        op_valid = 1'b1; op = o; A = a; B = b;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            n = k;
            if (k == 1) begin
                op_valid = 1'b0;
                A = $urandom;
                B = $urandom;
            end
            if (inj && k == 5) begin
                op_valid = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF;
            end
            if (inj && k == 6) op_valid = 1'b0;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 0;
            if (hi !== h0 || lo !== l0) hold_ok = 0;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        e = sb_q.pop_front();
        chk({tag, " hi"}, hi, e[63:32]);
        chk({tag, " lo"}, lo, e[31:0]);
        chk({tag, " busy at done"}, {31'b0, busy}, 32'd0);
        chk({tag, " busy while running"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, " hi/lo hold"}, {31'b0, hold_ok}, 32'd1);
    endtask

    initial begin
        bit no_done;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        op_valid = 1'b1; op = 3'd4; A = 32'h1234_5678;
        @(negedge clk);
        op_valid = 1'b0;
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi done", {31'b0, done}, 32'd0);
        chk("mthi busy", {31'b0, busy}, 32'd0);
        op_valid = 1'b1; op = 3'd5; A = 32'h9ABC_DEF0;
        @(negedge clk);
        op_valid = 1'b0;
        chk("mtlo lo", lo, 32'h9ABC_DEF0);
        chk("mtlo hi kept", hi, 32'h1234_5678);

        run_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
        @(negedge clk);
        chk("done one cycle", {31'b0, done}, 32'd0);

        run_op("mult neg", 3'd0, 32'hFFFF_FFFD, 32'd5, MUL_LAT, 0);
        run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 34, 0);
        run_op("divu back2back", 3'd3, 32'd7, 32'd2, 34, 0);
        run_op("divu by zero", 3'd3, 32'd100, 32'd0, 2, 0);
        run_op("div overflow mtlo ignored", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1);
        run_op("div signed rem", 3'd2, 32'd17, 32'hFFFF_FFFB, 34, 0);
        run_op("mult mixed", 3'd0, 32'h8000_0000, 32'h7FFF_FFFF, MUL_LAT, 0);

        for (int i = 0; i < 4; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            run_op("random op", ro, ra, rb, (ro < 3'd2) ? MUL_LAT : 34, 0);
        end

        // Abort an in-flight op at its 10th busy cycle
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
        op_valid = 1'b1; op = 3'd2; A = 32'd1000; B = 32'd7;
`else
        op_valid = 1'b1; op = 3'd0; A = 32'hFFFF_FFFD; B = 32'd5;
`endif
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) op_valid = 1'b0;
        end
        chk("busy before abort", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        no_done = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 0;
        end
        chk("no done after abort", {31'b0, no_done}, 32'd1);

        run_op("multu after abort", 3'd1, 32'd3, 32'd4, MUL_LAT, 0);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
